// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: walks NDIGITS through a shared
// hex decoder with anti-ghost blanking, a one-deep shadow buffer and leading-zero blanking.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | after reset, nothing displayed, waiting for the first value
// S_BLANK | all digits off for BLANK_CYCLES, decoder settling on idx nibble
// S_SHOW  | digit idx lit for REFRESH_DIV cycles with registered segments
module seven_seg_scan_ctrl #(
  parameter int NDIGITS      = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [4*NDIGITS-1:0]   load_value,
  output logic                   load_ready,
  input  logic                   blank_lz,
  output logic [3:0]             hex_out,
  input  logic [6:0]             seg_in,
  output logic [6:0]             seg_out,
  output logic [NDIGITS-1:0]     digit_en,
  output logic                   frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NDIGITS);

  localparam logic [CW-1:0] BLANK_LOAD   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] REFRESH_LOAD = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*NDIGITS-1:0] active_q, active_d;
  logic [4*NDIGITS-1:0] pending_q, pending_d;
  logic                 pfull_q, pfull_d;
  logic [6:0]           seg_q, seg_d;

  logic                 xfer;
  logic                 cnt_tc;
  logic                 frame_end;
  logic [3:0]           nib [NDIGITS];
  logic [NDIGITS-1:0]   upper_zero;
  logic                 suppress;
  logic                 show_on;

  assign xfer      = load_valid && !pfull_q;
  assign cnt_tc    = (cnt_q == '0);
  assign frame_end = (state_q == S_SHOW) && cnt_tc && (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pfull_q   <= 1'b0;
      seg_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pfull_q   <= pfull_d;
      seg_q     <= seg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pfull_d    = pfull_q;
    seg_d      = seg_q;
    hex_out    = 4'h0;
    seg_out    = 7'h00;
    digit_en   = '0;
    frame_done = frame_end;
    load_ready = !pfull_q;
    suppress   = 1'b0;
    show_on    = 1'b0;

    for (int i = 0; i < NDIGITS; i++) begin
      nib[i] = active_q[4*i +: 4];
    end
    // upper_zero[i]: every nibble from i up to the top is zero
    upper_zero[NDIGITS-1] = (nib[NDIGITS-1] == 4'h0);
    for (int i = NDIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (nib[i] == 4'h0);
    end

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          active_d = load_value;
          state_d  = S_BLANK;
          idx_d    = '0;
          cnt_d    = BLANK_LOAD;
        end
      end
      S_BLANK: begin
        if (cnt_tc) begin
          state_d = S_SHOW;
          cnt_d   = REFRESH_LOAD;
          seg_d   = seg_in;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SHOW: begin
        if (cnt_tc) begin
          state_d = S_BLANK;
          cnt_d   = BLANK_LOAD;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // active only changes at a frame boundary; mid-frame loads park in pending
    if (state_q != S_IDLE) begin
      if (frame_end) begin
        if (xfer) begin
          active_d = load_value;
        end else if (pfull_q) begin
          active_d = pending_q;
          pfull_d  = 1'b0;
        end
      end else if (xfer) begin
        pending_d = load_value;
        pfull_d   = 1'b1;
      end
      hex_out = nib[idx_q];
    end

    suppress = blank_lz && (idx_q != '0) && upper_zero[idx_q];
    show_on  = (state_q == S_SHOW) && !suppress;
    if (show_on) begin
      digit_en = NDIGITS'(1) << idx_q;
      seg_out  = seg_q;
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing controller that shares one combinational hex-to-seven-segment decoder across NDIGITS common-anode/cathode display digits. It holds a packed multi-digit hex value and walks the digits in a fixed scan order. For each digit it drives the nibble to the shared decoder, registers the decoded segments, and enables that digit alone. It sits between the value producer (load handshake) and the display pins, and includes a one-deep shadow buffer and optional leading-zero blanking.

## Interface

- NDIGITS, 4: number of multiplexed digits (≥2).
- REFRESH_DIV, 1000: clk cycles each digit is shown (≥1).
- BLANK_CYCLES, 2: all-digits-off cycles before each digit, for anti-ghosting (≥1).

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- load_valid  in  1  producer presents load_value.
- load_value  in  4*NDIGITS  packed hex; nibble i = bits [4i+3:4i]; digit 0 = least significant.
- load_ready  out  1  controller can accept a value.
- blank_lz  in  1  enable leading-zero blanking; sampled every cycle.
- hex_out  out  4  nibble to shared decoder.
- seg_in  in  7  decoder result; bit6..bit0 = segments a,b,c,d,e,f,g, active-high.
- seg_out  out  7  registered segments to pins; same bit order.
- digit_en  out  NDIGITS  one-hot active-high digit enable; all-zero when blanked.
- frame_done  out  1  one-cycle pulse at end of each full scan.

## Operation

- Registers: active (4*NDIGITS), pending (4*NDIGITS) plus pending_full, digit index idx, phase counter, state.
- States:
  - IDLE: after reset.
  - BLANK: digit_en=0, seg_out=0, for BLANK_CYCLES cycles.
  - SHOW: for REFRESH_DIV cycles.
- Transfer: load_valid && load_ready on a rising edge.
- load_ready = !pending_full.
- Transfer in IDLE: value goes to active; next state is BLANK, idx=0.
- Transfer during BLANK/SHOW, not the frame_done cycle: value goes to pending; pending_full=1.
- Frame end (frame_done cycle): if pending_full, pending moves to active and pending_full clears.
- Transfer in the frame_done cycle (only possible when pending_full=0): bypasses to active directly, so the new value is used from the next frame.
- active is never modified mid-frame.
- hex_out = active nibble idx in BLANK and SHOW; 0 in IDLE.
- seg_in is sampled on the last BLANK cycle and held in seg_out for the whole SHOW phase.
- Transitions:
  - BLANK → SHOW after BLANK_CYCLES.
  - SHOW → BLANK after REFRESH_DIV; idx increments and wraps NDIGITS-1 → 0.
  - No return to IDLE except by reset.
- In SHOW, digit_en = one-hot(idx), except digit idx is suppressed when all three hold: blank_lz=1, idx>0, and every nibble j ≥ idx of active is zero.
- When suppressed: digit_en=0 and seg_out=0 for that slot; slot timing is unchanged.
- Digit 0 is never suppressed.
- frame_done=1 on the final SHOW cycle of idx=NDIGITS-1.

## Timing

- Reset values (edge after reset=0):
  - state=IDLE, idx=0, pending_full=0.
  - hex_out=0, seg_out=0, digit_en=0, load_ready=1, frame_done=0.
  - active and pending cleared.
- Reset mid-operation aborts the scan and discards pending with no partial output.
- Frame length = NDIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- Latency from IDLE transfer edge:
  - BLANK for digit 0 begins next cycle.
  - First SHOW cycle is BLANK_CYCLES+1 cycles after the transfer edge.
- Pending value becomes visible in the BLANK immediately after the next frame_done.
- Decoder path: hex_out → seg_in is combinational, single-cycle; the controller adds exactly one register.
- digit_en and seg_out change on the same edge; digit_en is never more than one-hot.

## Test plan

Parameters for all scenarios: NDIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, frame length 20.

- Reset then idle, no load: all outputs at reset values for 50 cycles; load_ready=1, frame_done never asserts.
- Load 16'h12AF, blank_lz=0: SHOW slots produce, in order:
  - digit_en 0001 with seg_out 1000111;
  - 0010 with 1110111;
  - 0100 with 1101101;
  - 1000 with 0110000.
  - Each slot lasts 4 cycles and is preceded by 1 cycle of digit_en=0; frame_done repeats every 20 cycles.
- Load 16'h0050, blank_lz=1: digit 0 shows 1111110 and digit 1 shows 1011011; digits 2 and 3 show digit_en=0, seg_out=0 during their slots. Load 16'h0000: only digit 0 lit.
- Back-to-back loads mid-frame:
  - First load is accepted; load_ready drops.
  - Second load_valid is held off until the cycle after frame_done, when load_ready rises again.
  - The first value is displayed from the next frame.
  - A load coinciding with frame_done (pending empty) is displayed in the very next frame.
- Assert reset in the 3rd SHOW cycle of digit 2 with a pending value: next edge all outputs return to reset values, load_ready=1; after release no digit lights until a new load.
